// File: rtl/source_mealy_fsm.sv
// Overlapping Mealy detector for the serial pattern 1-0-1-1-0 (first bit first).
// The detect flag y is combinational from the current state and x, with no output register.
module source_mealy_fsm (
    output logic [0:0] y,
    output logic [2:0] cs,
    output logic [2:0] ns,
    input  logic       x,
    input  logic       rst,
    input  logic       clk
);

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_e;

    state_e cs_q;
    state_e ns_d;
    logic   y_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q <= S0;
        end else begin
            cs_q <= ns_d;
        end
    end

    always_comb begin
        ns_d = S0;
        y_d  = 1'b0;
        if (!rst) begin
            unique case (cs_q)
                S0: ns_d = x ? S1 : S0;
                S1: ns_d = x ? S1 : S2;
                S2: ns_d = x ? S3 : S0;
                S3: ns_d = x ? S4 : S2;
                S4: begin
                    // Match keeps the "10" suffix so overlapping patterns are caught.
                    ns_d = x ? S1 : S2;
                    y_d  = ~x;
                end
                default: ns_d = S0;
            endcase
        end
    end

    assign y  = y_d;
    assign cs = cs_q;
    assign ns = ns_d;

endmodule

// File: tb/tb_source_mealy_fsm.sv
// Directed bench for source_mealy_fsm: hand-computed vectors plus a table-driven model
// checked every cycle over a 64-bit stream.
module tb_source_mealy_fsm;

    logic       clk;
    logic       rst;
    logic       x;
    logic [0:0] y;
    logic [2:0] cs;
    logic [2:0] ns;

    int n_checks;
    int n_fail;

    logic [3:0]  tbl [0:15];
    logic [63:0] stream;
    logic [2:0]  ms;
    logic [3:0]  ent;

    source_mealy_fsm dut (
        .y  (y),
        .cs (cs),
        .ns (ns),
        .x  (x),
        .rst(rst),
        .clk(clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the
    // next rising edge.
    task automatic drive(input logic xb, input logic rb);
        @(negedge clk);
        x   = xb;
        rst = rb;
        #1;
    endtask

    task automatic vec(input string tag, input logic xb, input logic [2:0] ecs,
                       input logic [2:0] ens, input logic ey);
        drive(xb, 1'b0);
        check_eq({tag, ".cs"}, {29'd0, cs}, {29'd0, ecs});
        check_eq({tag, ".ns"}, {29'd0, ns}, {29'd0, ens});
        check_eq({tag, ".y"}, {31'd0, y}, {31'd0, ey});
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1);
        check_eq("rst.ns", {29'd0, ns}, 32'd0);
        check_eq("rst.y", {31'd0, y}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        x        = 1'b0;
        rst      = 1'b1;

        // {ns, y} indexed by {state, x}; unused states fall back to S0.
        for (int i = 0; i < 16; i++) tbl[i] = 4'b0000;
        tbl[4'b0000] = {3'd0, 1'b0};
        tbl[4'b0001] = {3'd1, 1'b0};
        tbl[4'b0010] = {3'd2, 1'b0};
        tbl[4'b0011] = {3'd1, 1'b0};
        tbl[4'b0100] = {3'd0, 1'b0};
        tbl[4'b0101] = {3'd3, 1'b0};
        tbl[4'b0110] = {3'd2, 1'b0};
        tbl[4'b0111] = {3'd4, 1'b0};
        tbl[4'b1000] = {3'd2, 1'b1};
        tbl[4'b1001] = {3'd1, 1'b0};

        // 1: reset, then idle on zeros
        do_reset();
        for (int i = 0; i < 4; i++) vec("idle", 1'b0, 3'd0, 3'd0, 1'b0);

        // 2: single pattern
        do_reset();
        vec("p1.b1", 1'b1, 3'd0, 3'd1, 1'b0);
        vec("p1.b2", 1'b0, 3'd1, 3'd2, 1'b0);
        vec("p1.b3", 1'b1, 3'd2, 3'd3, 1'b0);
        vec("p1.b4", 1'b1, 3'd3, 3'd4, 1'b0);
        vec("p1.b5", 1'b0, 3'd4, 3'd2, 1'b1);

        // 3: overlapping detection
        do_reset();
        vec("ov.b1", 1'b1, 3'd0, 3'd1, 1'b0);
        vec("ov.b2", 1'b0, 3'd1, 3'd2, 1'b0);
        vec("ov.b3", 1'b1, 3'd2, 3'd3, 1'b0);
        vec("ov.b4", 1'b1, 3'd3, 3'd4, 1'b0);
        vec("ov.b5", 1'b0, 3'd4, 3'd2, 1'b1);
        vec("ov.b6", 1'b1, 3'd2, 3'd3, 1'b0);
        vec("ov.b7", 1'b1, 3'd3, 3'd4, 1'b0);
        vec("ov.b8", 1'b0, 3'd4, 3'd2, 1'b1);
        vec("ov.end", 1'b0, 3'd2, 3'd0, 1'b0);

        // 4: near miss, then recovery into a match
        do_reset();
        vec("nm.b1", 1'b1, 3'd0, 3'd1, 1'b0);
        vec("nm.b2", 1'b0, 3'd1, 3'd2, 1'b0);
        vec("nm.b3", 1'b1, 3'd2, 3'd3, 1'b0);
        vec("nm.b4", 1'b1, 3'd3, 3'd4, 1'b0);
        vec("nm.b5", 1'b1, 3'd4, 3'd1, 1'b0);
        vec("nm.b6", 1'b0, 3'd1, 3'd2, 1'b0);
        vec("nm.b7", 1'b1, 3'd2, 3'd3, 1'b0);
        vec("nm.b8", 1'b1, 3'd3, 3'd4, 1'b0);
        vec("nm.b9", 1'b0, 3'd4, 3'd2, 1'b1);

        // 5: reset mid-sequence drops the partial match
        do_reset();
        vec("mr.b1", 1'b1, 3'd0, 3'd1, 1'b0);
        vec("mr.b2", 1'b0, 3'd1, 3'd2, 1'b0);
        vec("mr.b3", 1'b1, 3'd2, 3'd3, 1'b0);
        vec("mr.b4", 1'b1, 3'd3, 3'd4, 1'b0);
        drive(1'b0, 1'b1);
        check_eq("mr.rst.ns", {29'd0, ns}, 32'd0);
        check_eq("mr.rst.y", {31'd0, y}, 32'd0);
        check_eq("mr.rst.cs", {29'd0, cs}, 32'd4);
        vec("mr.after", 1'b0, 3'd0, 3'd0, 1'b0);

        // 6: long stream against the table model
        stream = 64'b0001010101100100110110011100011000110010000111001010111100111011;
        do_reset();
        ms = 3'd0;
        for (int i = 0; i < 64; i++) begin
            ent = tbl[{ms, stream[63-i]}];
            vec("stream", stream[63-i], ms, ent[3:1], ent[0]);
            ms = ent[3:1];
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
